// File: rtl/la_uart_rx.sv
// la_uart_rx: UART receive front-end.
//
// Synchronizes the asynchronous uart_rx pad, recovers frames with 16x oversampling
// derived from a programmable divisor, and presents each character with its error
// flags on a valid/ready output register.
//
// Ports:
//   clk          core clock
//   nreset       active-low reset, asynchronous assert
//   en           receiver enable; 0 forces the frame FSM idle
//   div          oversample tick period minus 1 (bit period = 16*(div+1) clk)
//   parity_en    a parity bit follows the data bits
//   parity_odd   1 = odd parity, 0 = even parity
//   uart_rx      serial input from the pad, idle high
//   rx_valid     character available in the output register
//   rx_data      received character (LSB first on the line)
//   rx_ready     consumer accepts the character
//   err_frame    stop bit sampled low (qualified by rx_valid)
//   err_parity   parity mismatch (qualified by rx_valid)
//   err_overrun  one-cycle pulse when a completed character is dropped
//   busy         frame FSM is not idle
module la_uart_rx #(
  parameter int unsigned DW   = 8,
  parameter int unsigned DIVW = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  input  logic            parity_en,
  input  logic            parity_odd,
  input  logic            uart_rx,
  output logic            rx_valid,
  output logic [DW-1:0]   rx_data,
  input  logic            rx_ready,
  output logic            err_frame,
  output logic            err_parity,
  output logic            err_overrun,
  output logic            busy
);

  localparam int unsigned BCW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer (both stages reset to the idle-high line level)
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rxs_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample prescaler
  // ---------------------------------------------------------------------------
  logic [DIVW-1:0] presc_q, presc_d;
  logic            tick;

  // >= rather than == so a divisor lowered on the fly cannot strand the counter
  // above the new terminal count for a full wrap.
  assign tick = en && (presc_q >= div);

  always_comb begin
    presc_d = presc_q + DIVW'(1);
    if (!en || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            armed_q, armed_d;
  logic            done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    armed_d   = armed_q;
    done_d    = 1'b0;

    // 4-bit wrap gives the 16-tick bit period in DATA without an explicit reload.
    if (tick) begin
      cnt_d = cnt_q + 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        // A start edge is only trusted after the line has been seen idle high.
        if (rxs_q) begin
          armed_d = 1'b1;
        end
        if (tick && armed_q && !rxs_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick && (cnt_q == 4'd7)) begin
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          state_d   = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (tick && (cnt_q == 4'd15)) begin
          shift_d = {rxs_q, shift_q[DW-1:1]};
          if (bit_cnt_q == BCW'(DW - 1)) begin
            state_d = parity_en ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      StParity: begin
        if (tick && (cnt_q == 4'd15)) begin
          perr_d  = ((^shift_q) ^ rxs_q) != parity_odd;
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick && (cnt_q == 4'd15)) begin
          ferr_d  = ~rxs_q;
          done_d  = 1'b1;
          state_d = StIdle;
          // A low stop bit may be a break or a mid-frame sync loss: wait for idle.
          if (!rxs_q) begin
            armed_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // Disable drops any partial frame; the output register is left alone.
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register with valid/ready handshake
  // ---------------------------------------------------------------------------
  logic          rx_valid_q, rx_valid_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          err_frame_q, err_frame_d;
  logic          err_parity_q, err_parity_d;
  logic          err_overrun_q, err_overrun_d;

  always_comb begin
    rx_valid_d    = rx_valid_q;
    rx_data_d     = rx_data_q;
    err_frame_d   = err_frame_q;
    err_parity_d  = err_parity_q;
    err_overrun_d = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // A character completing while the slot drains takes the slot directly.
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d   = 1'b1;
        rx_data_d    = shift_q;
        err_frame_d  = ferr_q;
        err_parity_d = perr_q;
      end else begin
        err_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      err_frame_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      err_frame_q   <= err_frame_d;
      err_parity_q  <= err_parity_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign err_frame   = err_frame_q;
  assign err_parity  = err_parity_q;
  assign err_overrun = err_overrun_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_la_uart_rx.sv
// tb_la_uart_rx: directed self-checking bench for la_uart_rx (DW=8, div=3).
//
// Stimulus pushes the character each frame must yield (data and error flags
// derived from the line encoding) into a queue; a compare process pops it on
// every transfer and checks held characters each cycle rx_valid waits.
module tb_la_uart_rx;

  localparam int unsigned DW   = 8;
  localparam int unsigned DIVW = 16;
  localparam int          BIT  = 64;  // 16 * (div + 1) with div = 3

  logic            clk = 1'b0;
  logic            nreset = 1'b1;
  logic            en = 1'b0;
  logic [DIVW-1:0] div = 16'd3;
  logic            parity_en = 1'b0;
  logic            parity_odd = 1'b0;
  logic            uart_rx = 1'b1;
  logic            rx_ready = 1'b1;
  logic            rx_valid;
  logic [DW-1:0]   rx_data;
  logic            err_frame;
  logic            err_parity;
  logic            err_overrun;
  logic            busy;

  la_uart_rx #(
    .DW  (DW),
    .DIVW(DIVW)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .en         (en),
    .div        (div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .uart_rx    (uart_rx),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .err_frame  (err_frame),
    .err_parity (err_parity),
    .err_overrun(err_overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t       expq[$];
  exp_t       e;
  logic [9:0] last_char = '0;
  int         checks = 0;
  int         failures = 0;
  int         ovr_seen = 0;
  int         p0 = 0;
  int         q = 0;
  int         t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    if (!nreset) begin
      // nothing meaningful during reset
    end else begin
      if (err_overrun) ovr_seen++;
      if (rx_valid && !rx_ready && expq.size() != 0) begin
        chk("held_char", 32'({rx_data, err_frame, err_parity}), 32'(expq[0]));
      end
      if (rx_valid && rx_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_char actual=%0h required=none", rx_data);
        end else begin
          e = expq.pop_front();
          chk("char", 32'({rx_data, err_frame, err_parity}), 32'(e));
        end
        last_char = {rx_data, err_frame, err_parity};
      end
    end
  end

  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reprogram with the receiver disabled; prescaler restarts from 0 at p0.
  task automatic cfg(input logic pe, input logic po);
    @(posedge clk);
    #1;
    en = 1'b0;
    parity_en = pe;
    parity_odd = po;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    p0 = cyc;
  endtask

  // Place the start edge so the synchronized low lands on a tick cycle.
  task automatic align();
    while (((cyc - p0 - 1) % 4) != 0) begin
      @(posedge clk);
      #1;
    end
    q = cyc;
  endtask

  task automatic send(input logic [7:0] d, input logic pbit, input logic stopb,
                      input logic load);
    if (load) begin
      expq.push_back({d, ~stopb, parity_en & (((^d) ^ pbit) != parity_odd)});
    end
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
    if (parity_en) drive(pbit, BIT);
    drive(stopb, BIT);
  endtask

  initial begin
    #2 nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rx_valid), 0);
    chk("reset_data", 32'(rx_data), 0);
    chk("reset_flags", 32'({err_frame, err_parity, err_overrun}), 0);
    chk("reset_busy", 32'(busy), 0);
    nreset = 1'b1;

    // Idle line
    cfg(1'b0, 1'b0);
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_valid", 32'(rx_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_flags", 32'({err_frame, err_parity, err_overrun}), 0);

    // 8N1 0xA5: rx_valid rises 612 cycles after the start edge, for one cycle
    align();
    fork
      send(8'hA5, 1'b0, 1'b1, 1'b1);
      begin
        t = 0;
        @(negedge clk);
        while (!rx_valid && t < 800) begin
          @(negedge clk);
          t++;
        end
        chk("a5_latency", 32'(cyc - q), 612);
        chk("a5_data", 32'(rx_data), 32'h A5);
        chk("a5_flags", 32'({err_frame, err_parity}), 0);
        @(negedge clk);
        chk("a5_one_cycle", 32'(rx_valid), 0);
      end
    join

    // Start glitch of 20 cycles
    align();
    drive(1'b0, 20);
    chk("glitch_busy", 32'(busy), 1);
    drive(1'b1, 100);
    chk("glitch_idle", 32'(busy), 0);
    chk("glitch_no_valid", 32'(rx_valid), 0);

    // Parity
    cfg(1'b1, 1'b0);
    align();
    send(8'h03, 1'b1, 1'b1, 1'b1);
    chk("par_even_bad", 32'(last_char), 32'({8'h03, 1'b0, 1'b1}));
    send(8'h03, 1'b0, 1'b1, 1'b1);
    chk("par_even_good", 32'(last_char), 32'({8'h03, 1'b0, 1'b0}));
    cfg(1'b1, 1'b1);
    align();
    send(8'h07, 1'b0, 1'b1, 1'b1);
    chk("par_odd_good", 32'(last_char), 32'({8'h07, 1'b0, 1'b0}));

    // Frame error, then a held-low line must not start a frame until idle
    cfg(1'b1, 1'b0);
    align();
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("frame_err", 32'(last_char), 32'({8'h3C, 1'b1, 1'b0}));
    drive(1'b0, 2 * BIT);
    chk("frame_no_restart", 32'(busy), 0);
    drive(1'b1, BIT);
    send(8'h55, 1'b0, 1'b1, 1'b1);
    chk("frame_recover", 32'(last_char), 32'({8'h55, 1'b0, 1'b0}));

    // Overrun, then drain exactly on the completion cycle
    cfg(1'b0, 1'b0);
    rx_ready = 1'b0;
    align();
    send(8'h11, 1'b0, 1'b1, 1'b1);
    send(8'h22, 1'b0, 1'b1, 1'b0);
    drive(1'b1, BIT);
    chk("ovr_once", 32'(ovr_seen), 1);
    chk("ovr_keep_valid", 32'(rx_valid), 1);
    chk("ovr_keep_data", 32'(rx_data), 32'h11);
    cfg(1'b0, 1'b0);
    align();
    fork
      send(8'h33, 1'b0, 1'b1, 1'b1);
      begin
        repeat (611) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_valid_stays", 32'(rx_valid), 1);
        chk("drain_new_data", 32'(rx_data), 32'h33);
      end
    join
    chk("drain_no_overrun", 32'(ovr_seen), 1);

    // Reset in the middle of DATA
    cfg(1'b0, 1'b0);
    align();
    fork
      send(8'h5A, 1'b0, 1'b1, 1'b0);
      begin
        repeat (300) @(posedge clk);
        #1;
        chk("rst_mid_busy", 32'(busy), 1);
        #1 nreset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(rx_valid), 0);
        repeat (360) @(posedge clk);
        #1 nreset = 1'b1;
      end
    join
    cfg(1'b0, 1'b0);
    drive(1'b1, 10);
    align();
    send(8'h5A, 1'b0, 1'b1, 1'b1);
    chk("rst_resend", 32'(last_char), 32'({8'h5A, 1'b0, 1'b0}));

    repeat (20) @(posedge clk);
    #1;
    chk("all_chars_seen", 32'(expq.size()), 0);
    chk("ovr_total", 32'(ovr_seen), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
